// File: rtl/fta_bus_pkg.sv
// FTA bus request/response types shared by the 128-to-32 bridge and its users.
// Also holds the bridge state encoding and the byte-lane-group helper.
package fta_bus_pkg;

  typedef enum logic [2:0] {
    SZ_NUL, SZ_BYT, SZ_WYDE, SZ_TETRA, SZ_PENTA, SZ_OCTA, SZ_HEXI, SZ_N96
  } fta_size_t;

  typedef struct packed {
    logic [7:0]   tid;
    logic [1:0]   om;
    logic [4:0]   cmd;
    fta_size_t    sz;
    logic [3:0]   cache;
    logic [7:0]   pl;
    logic [3:0]   pri;
    logic [3:0]   seg;
    logic         csr;
    logic [15:0]  asid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  vadr;
    logic [31:0]  padr;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic [7:0]   tid;
    logic [1:0]   om;
    logic [4:0]   cmd;
    fta_size_t    sz;
    logic [3:0]   cache;
    logic [7:0]   pl;
    logic [3:0]   pri;
    logic [3:0]   seg;
    logic         csr;
    logic [15:0]  asid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [3:0]   sel;
    logic [31:0]  vadr;
    logic [31:0]  padr;
    logic [31:0]  dat;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic [7:0]   tid;
    logic         stall;
    logic         next;
    logic         ack;
    logic         rty;
    logic         err;
    logic [3:0]   pri;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic [7:0]   tid;
    logic         stall;
    logic         next;
    logic         ack;
    logic         rty;
    logic         err;
    logic [3:0]   pri;
    logic [31:0]  adr;
    logic [31:0]  dat;
  } fta_cmd_response32_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fta_bridge_state_t;

  // One bit per 32-bit word that has any byte selected.
  function automatic logic [3:0] fta_lane_mask4(input logic [15:0] sel128);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = |sel128[4*i +: 4];
    return m;
  endfunction

endpackage

// File: rtl/fta_lane_sequencer.sv
// Holds the pending lane mask and presents the lowest pending lane.
// Advancing retires the current lane; o_last flags that it was the final one.
module fta_lane_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_load,
  input  logic [3:0] i_mask,
  input  logic       i_advance,
  output logic [1:0] o_idx,
  output logic       o_last
);
  logic [3:0] r_lanes;
  logic [3:0] w_rest;

  always_comb begin
    o_idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (r_lanes[i]) o_idx = 2'(i);
    w_rest = r_lanes & ~(4'b0001 << o_idx);
    o_last = (w_rest == 4'b0000);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          r_lanes <= 4'b0000;
    else if (i_load)    r_lanes <= i_mask;
    else if (i_advance) r_lanes <= w_rest;
  end
endmodule

// File: rtl/fta_bridge128to32_split.sv
// Sequential 128-to-32 FTA down-converter: one narrow beat per active word,
// read data assembled into a single wide response with retry/timeout folding.
module fta_bridge128to32_split
  import fta_bus_pkg::*;
#(
  parameter int RTY_MAX      = 3,
  parameter int TMO_CYCLES   = 1023,
  parameter bit RD_REPLICATE = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request128_t  req128_i,
  output fta_cmd_response128_t resp128_o,
  output fta_cmd_request32_t   req32_o,
  input  fta_cmd_response32_t  resp32_i,
  output logic                 busy_o,
  output logic                 tmo_o
);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
  localparam logic [7:0]  RTY_LIM  = 8'(RTY_MAX);

  fta_bridge_state_t   r_state, w_state_n;
  fta_cmd_request128_t r_req;
  logic [127:0]        r_asm;
  logic                r_err, r_single;
  logic [7:0]          r_rty_cnt;
  logic [15:0]         r_tmo_cnt;

  logic [3:0] w_mask_in;
  logic [1:0] w_idx;
  logic       w_last, w_load, w_adv, w_enter, w_store, w_set_err, w_rty_inc;
  logic       w_active, w_tmo_hit, w_resp_any;
  logic [3:0] w_nib;
  logic       w_unused;

  assign w_mask_in  = fta_lane_mask4(req128_i.sel);
  assign w_active   = (r_state == ISSUE) || (r_state == WAIT);
  assign w_resp_any = resp32_i.err | resp32_i.ack | resp32_i.rty;
  assign w_tmo_hit  = (TMO_CYCLES != 0) && w_active && (r_tmo_cnt == TMO_LAST);
  // A real slave response in the same cycle beats the timeout.
  assign tmo_o      = w_tmo_hit && !((r_state == WAIT) && w_resp_any);
  assign busy_o     = (r_state != IDLE);
  assign w_nib      = r_req.sel[{w_idx, 2'b00} +: 4];
  assign w_unused   = ^{r_req.cyc, r_req.stb, resp32_i.tid, resp32_i.stall & 1'b0,
                        resp32_i.adr, resp32_i.rty & 1'b0};

  fta_lane_sequencer u_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_load),
    .i_mask   (w_mask_in),
    .i_advance(w_adv),
    .o_idx    (w_idx),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_enter   = 1'b0;
    w_store   = 1'b0;
    w_set_err = 1'b0;
    w_rty_inc = 1'b0;
    unique case (r_state)
      IDLE: if (req128_i.cyc && req128_i.stb) begin
        w_load = 1'b1;
        if (w_mask_in == 4'b0000) begin
          w_set_err = 1'b1;
          w_state_n = RESP;
        end else begin
          w_enter   = 1'b1;
          w_state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (tmo_o) begin
          w_set_err = 1'b1;
          w_state_n = RESP;
        end else if (!resp32_i.stall) w_state_n = WAIT;
      end
      WAIT: begin
        if (resp32_i.err) begin
          w_set_err = 1'b1;
          w_state_n = RESP;
        end else if (resp32_i.ack) begin
          w_store   = !r_req.we;
          w_adv     = 1'b1;
          w_enter   = !w_last;
          w_state_n = w_last ? RESP : ISSUE;
        end else if (resp32_i.rty) begin
          if (r_rty_cnt == RTY_LIM) begin
            w_set_err = 1'b1;
            w_state_n = RESP;
          end else begin
            w_rty_inc = 1'b1;
            w_enter   = 1'b1;
            w_state_n = ISSUE;
          end
        end else if (tmo_o) begin
          w_set_err = 1'b1;
          w_state_n = RESP;
        end
      end
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_asm     <= '0;
      r_err     <= 1'b0;
      r_single  <= 1'b0;
      r_rty_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_load) begin
        r_req     <= req128_i;
        r_asm     <= '0;
        r_err     <= 1'b0;
        r_single  <= $onehot(w_mask_in);
        r_rty_cnt <= '0;
      end
      if (w_set_err) r_err <= 1'b1;
      if (w_store) begin
        if (RD_REPLICATE && r_single) r_asm <= {4{resp32_i.dat}};
        else                          r_asm[{w_idx, 5'b00000} +: 32] <= resp32_i.dat;
      end
      if (w_adv)          r_rty_cnt <= '0;
      else if (w_rty_inc) r_rty_cnt <= r_rty_cnt + 8'd1;
      if (w_enter)        r_tmo_cnt <= '0;
      else if (w_active)  r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  always_comb begin
    req32_o   = '0;
    resp128_o = '0;
    if (w_active) begin
      req32_o.cyc   = 1'b1;
      req32_o.stb   = (r_state == ISSUE);
      req32_o.we    = r_req.we;
      req32_o.sel   = w_nib;
      req32_o.padr  = {r_req.padr[31:4], w_idx, 2'b00};
      req32_o.vadr  = {r_req.vadr[31:4], w_idx, 2'b00};
      req32_o.dat   = r_req.data1[{w_idx, 5'b00000} +: 32];
      req32_o.sz    = (w_nib == 4'hF) ? SZ_TETRA : r_req.sz;
      req32_o.tid   = r_req.tid;
      req32_o.om    = r_req.om;
      req32_o.cmd   = r_req.cmd;
      req32_o.pl    = r_req.pl;
      req32_o.pri   = r_req.pri;
      req32_o.cache = r_req.cache;
      req32_o.asid  = r_req.asid;
      req32_o.seg   = r_req.seg;
      req32_o.csr   = r_req.csr;
    end
    if (busy_o) begin
      resp128_o.stall = 1'b1;
      resp128_o.next  = resp32_i.next;
      resp128_o.pri   = resp32_i.pri;
    end
    if (r_state == RESP) begin
      resp128_o.ack = !r_err;
      resp128_o.err = r_err;
      resp128_o.tid = r_req.tid;
      resp128_o.adr = r_req.padr;
      resp128_o.dat = r_asm;
    end
  end
endmodule
